// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment encode/decode pair.
// Segment constants are in seven[7:1] order, {g,f,e,d,c,b,a}, where 1 = lit.
// Also holds the stability tracker state type and the one-hot helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD   = 4'hE;

  // Widest digit select supported; narrower selects are zero-extended.
  localparam int MAX_DIG = 8;

  typedef enum logic [1:0] {
    TRK_IDLE  = 2'd0,
    TRK_COUNT = 2'd1,
    TRK_HELD  = 2'd2
  } trk_state_e;

  function automatic logic is_onehot(input logic [MAX_DIG-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DIG; i++) begin
      n = n + int'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/seven_bcd.sv
// Inverse seven-segment lookup: segment pattern -> BCD digit plus error flag.
// Ports:
//   seven_i [7:1] : segment pattern {g,f,e,d,c,b,a}, 1 = lit
//   bcd_o   [3:0] : 0..9, BCD_BLANK for an unlit pattern, BCD_BAD otherwise
//   err_o         : 1 when the pattern is neither a digit nor blank
module seven_bcd
  import seven_seg_pkg::*;
(
  input  logic [7:1] seven_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = BCD_BAD;
    err_o = 1'b1;
    case (seven_i)
      SEG_0:     begin bcd_o = 4'd0;      err_o = 1'b0; end
      SEG_1:     begin bcd_o = 4'd1;      err_o = 1'b0; end
      SEG_2:     begin bcd_o = 4'd2;      err_o = 1'b0; end
      SEG_3:     begin bcd_o = 4'd3;      err_o = 1'b0; end
      SEG_4:     begin bcd_o = 4'd4;      err_o = 1'b0; end
      SEG_5:     begin bcd_o = 4'd5;      err_o = 1'b0; end
      SEG_6:     begin bcd_o = 4'd6;      err_o = 1'b0; end
      SEG_7:     begin bcd_o = 4'd7;      err_o = 1'b0; end
      SEG_8:     begin bcd_o = 4'd8;      err_o = 1'b0; end
      SEG_9:     begin bcd_o = 4'd9;      err_o = 1'b0; end
      SEG_BLANK: begin bcd_o = BCD_BLANK; err_o = 1'b0; end
      default:   begin bcd_o = BCD_BAD;   err_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seven_bcd_capture.sv
// Snoops a multiplexed seven-segment bus and rebuilds the displayed BCD digits.
// A {dig_sel, seven} sample must repeat STABLE times in a row before it is
// accepted. An accepted one-hot select writes the decoded digit into its slot.
// An accepted multi-hot select raises scan_err. An accepted all-zero select is
// the blanking gap and is ignored.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   seven [7:1]   : segment lines {g,f,e,d,c,b,a}
//   dig_sel       : one-hot digit select
//   bcd_out       : digit i at [4i+3:4i]
//   err_out       : bit i = last accepted pattern for digit i was illegal
//   frame_valid   : one-cycle pulse once every digit has been accepted
//   scan_err      : one-cycle pulse on an accepted multi-hot select
module seven_bcd_capture
  import seven_seg_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:1]           seven,
  input  logic [NDIG-1:0]      dig_sel,
  output logic [4*NDIG-1:0]    bcd_out,
  output logic [NDIG-1:0]      err_out,
  output logic                 frame_valid,
  output logic                 scan_err
);

  localparam int         SW      = NDIG + 7;
  localparam logic [3:0] CNT_MAX = 4'(STABLE);
  localparam logic [3:0] CNT_PRE = 4'(STABLE - 1);

  logic [SW-1:0]       samp;
  logic [SW-1:0]       prev_q;
  trk_state_e          state_q;
  logic [3:0]          cnt_q;
  logic [NDIG-1:0]     mask_q, mask_d;
  logic [4*NDIG-1:0]   bcd_q;
  logic [NDIG-1:0]     err_q;
  logic                fv_q, se_q;

  logic [MAX_DIG-1:0]  sel_ext;
  logic                same, sel_onehot, sel_zero, qualify, commit, multi_hot;
  logic [3:0]          dec_bcd;
  logic                dec_err;

  assign samp    = {dig_sel, seven};
  assign sel_ext = MAX_DIG'(dig_sel);

  // Only the sampled pattern is ever decoded; the select picks the slot.
  seven_bcd u_dec (
    .seven_i (seven),
    .bcd_o   (dec_bcd),
    .err_o   (dec_err)
  );

  // The run qualifies on the edge that takes it from STABLE-1 to STABLE, so
  // each stable run is acted on exactly once; HELD never re-qualifies.
  always_comb begin
    same       = (samp == prev_q);
    sel_onehot = is_onehot(sel_ext);
    sel_zero   = (dig_sel == '0);
    qualify    = (state_q == TRK_COUNT) && same && (cnt_q == CNT_PRE);
    commit     = qualify && sel_onehot;
    multi_hot  = !sel_zero && !sel_onehot;
    mask_d     = mask_q | dig_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRK_IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      bcd_q   <= {NDIG{BCD_BLANK}};
      err_q   <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      prev_q <= samp;
      fv_q   <= 1'b0;
      se_q   <= qualify && multi_hot;

      case (state_q)
        TRK_IDLE: begin
          state_q <= TRK_COUNT;
          cnt_q   <= 4'd1;
        end
        TRK_COUNT: begin
          if (!same) begin
            cnt_q <= 4'd1;
          end else if (cnt_q == CNT_PRE) begin
            state_q <= TRK_HELD;
            cnt_q   <= CNT_MAX;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        TRK_HELD: begin
          if (!same) begin
            state_q <= TRK_COUNT;
            cnt_q   <= 4'd1;
          end
        end
        default: begin
          state_q <= TRK_IDLE;
          cnt_q   <= '0;
        end
      endcase

      if (commit) begin
        for (int i = 0; i < NDIG; i++) begin
          if (dig_sel[i]) begin
            bcd_q[4*i +: 4] <= dec_bcd;
            err_q[i]        <= dec_err;
          end
        end
        // A completed frame pulses and starts collecting the next one at once.
        if (&mask_d) begin
          mask_q <= '0;
          fv_q   <= 1'b1;
        end else begin
          mask_q <= mask_d;
        end
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign err_out     = err_q;
  assign frame_valid = fv_q;
  assign scan_err    = se_q;

endmodule

// File: tb/tb_seven_bcd_capture.sv
module tb_seven_bcd_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:1]          seven = '0;
  logic [NDIG-1:0]     dig_sel = '0;
  logic [4*NDIG-1:0]   bcd_out;
  logic [NDIG-1:0]     err_out;
  logic                frame_valid, scan_err;

  always #5 clk = ~clk;

  seven_bcd_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seven       (seven),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .scan_err    (scan_err)
  );

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  // Digit glyphs, {g,f,e,d,c,b,a}.
  logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111};

  // Reference model state.
  logic [3:0]        m_bcd [NDIG];
  logic [NDIG-1:0]   m_err, m_mask;
  logic              m_fv, m_se;
  logic [NDIG+6:0]   m_last;
  int                m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void decode(input logic [6:0] seg, output logic [3:0] b, output logic e);
    b = 4'hE;
    e = 1'b1;
    if (seg == 7'b0) begin
      b = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (seg == segtab[k]) begin
        b = 4'(k);
        e = 1'b0;
      end
    end
  endfunction

  function automatic logic [4*NDIG-1:0] m_flat();
    logic [4*NDIG-1:0] f;
    for (int i = 0; i < NDIG; i++) f[4*i +: 4] = m_bcd[i];
    return f;
  endfunction

  // One clock edge of the reference: run length of identical samples; act
  // when a run reaches exactly STABLE.
  task automatic model_edge(input logic r, input logic [NDIG-1:0] sel, input logic [6:0] seg);
    logic [3:0] b;
    logic       e;
    if (r) begin
      for (int i = 0; i < NDIG; i++) m_bcd[i] = 4'hF;
      m_err = '0; m_mask = '0; m_fv = 1'b0; m_se = 1'b0;
      m_run = 0; m_last = '0;
      return;
    end
    m_fv = 1'b0;
    m_se = 1'b0;
    if (m_run > 0 && {sel, seg} == m_last) m_run++;
    else m_run = 1;
    m_last = {sel, seg};
    if (m_run == STABLE && sel != '0) begin
      if ($countones(sel) == 1) begin
        decode(seg, b, e);
        for (int i = 0; i < NDIG; i++) begin
          if (sel[i]) begin
            m_bcd[i] = b;
            m_err[i] = e;
          end
        end
        m_mask = m_mask | sel;
        if (m_mask == {NDIG{1'b1}}) begin
          m_fv   = 1'b1;
          m_mask = '0;
        end
      end else begin
        m_se = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [NDIG-1:0] sel, input logic [6:0] seg);
    rst = r; dig_sel = sel; seven = seg;
    @(posedge clk);
    model_edge(r, sel, seg);
    #1;
    check("bcd_out", 32'(bcd_out), 32'(m_flat()));
    check("err_out", 32'(err_out), 32'(m_err));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("scan_err", 32'(scan_err), 32'(m_se));
    if (frame_valid) fv_cnt++;
    if (scan_err) se_cnt++;
  endtask

  task automatic hold(input logic [NDIG-1:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(1'b0, sel, seg);
  endtask

  logic [4*NDIG-1:0] saved;
  logic [NDIG-1:0]   rsel;
  logic [6:0]        rseg;
  int                mode;

  initial begin
    for (int i = 0; i < NDIG; i++) m_bcd[i] = 4'hF;
    m_err = '0; m_mask = '0; m_fv = 1'b0; m_se = 1'b0; m_run = 0; m_last = '0;

    // Reset state.
    step(1'b1, 4'b0000, 7'b0);
    step(1'b1, 4'b0000, 7'b0);
    check("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
    check("rst_err", 32'(err_out), 32'h0);
    check("rst_pulses", 32'({frame_valid, scan_err}), 32'h0);

    // Full frame, with slot-0 timing.
    fv_cnt = 0;
    hold(4'b0001, 7'b1001111, 2);
    check("slot0_early", 32'(bcd_out[3:0]), 32'hF);
    hold(4'b0001, 7'b1001111, 1);
    check("slot0_ontime", 32'(bcd_out[3:0]), 32'h3);
    hold(4'b0001, 7'b1001111, 1);
    hold(4'b0010, 7'b1101101, 4);
    hold(4'b0100, 7'b0000110, 2);
    check("slot2_early", 32'(bcd_out[11:8]), 32'hF);
    hold(4'b0100, 7'b0000110, 2);
    hold(4'b1000, 7'b1111111, 2);
    check("fv_before_d3", 32'(fv_cnt), 32'd0);
    hold(4'b1000, 7'b1111111, 1);
    check("fv_at_d3", 32'(frame_valid), 32'd1);
    hold(4'b1000, 7'b1111111, 1);
    check("frame_bcd", 32'(bcd_out), 32'h8153);
    check("frame_fv_cnt", 32'(fv_cnt), 32'd1);

    // Glitch rejection.
    hold(4'b0001, 7'b1101101, 2);
    hold(4'b0001, 7'b0111111, 3);
    check("glitch_slot0", 32'(bcd_out[3:0]), 32'h0);

    // Illegal then blank on digit 1.
    hold(4'b0010, 7'b1010101, 3);
    check("illegal_slot1", 32'(bcd_out[7:4]), 32'hE);
    check("illegal_err1", 32'(err_out[1]), 32'd1);
    hold(4'b0010, 7'b0000000, 3);
    check("blank_slot1", 32'(bcd_out[7:4]), 32'hF);
    check("blank_err1", 32'(err_out[1]), 32'd0);

    // Multi-hot select.
    saved = bcd_out; se_cnt = 0; fv_cnt = 0;
    hold(4'b0011, 7'b0000110, 3);
    hold(4'b0011, 7'b0000110, 2);
    check("mh_scan_err_cnt", 32'(se_cnt), 32'd1);
    check("mh_bcd_same", 32'(bcd_out), 32'(saved));
    check("mh_no_fv", 32'(fv_cnt), 32'd0);

    // Reset mid-frame.
    fv_cnt = 0;
    hold(4'b0001, 7'b0000111, 4);
    hold(4'b0010, 7'b1111101, 4);
    step(1'b1, 4'b0010, 7'b1111101);
    check("midrst_bcd", 32'(bcd_out), 32'h0000FFFF);
    hold(4'b0100, 7'b1100110, 4);
    hold(4'b1000, 7'b1101111, 4);
    check("midrst_no_fv", 32'(fv_cnt), 32'd0);
    hold(4'b0001, 7'b1011011, 4);
    hold(4'b0010, 7'b0111111, 4);
    check("midrst_fv_after", 32'(fv_cnt), 32'd1);
    check("midrst_bcd_final", 32'(bcd_out), 32'h9402);

    // Randomized runs against the model.
    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 6) rsel = 4'(1 << $urandom_range(0, NDIG - 1));
      else if (mode < 8) rsel = 4'($urandom_range(0, 15));
      else rsel = '0;
      mode = int'($urandom_range(0, 9));
      if (mode < 7) rseg = segtab[$urandom_range(0, 9)];
      else if (mode < 8) rseg = 7'b0;
      else rseg = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 49) == 0) step(1'b1, rsel, rseg);
      else hold(rsel, rseg, int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_bcd_capture.md
Name: seven_bcd_capture

Overview:
- Reverse direction of the team's BCD-to-seven-segment encoder.
- Snoops a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and waits for each digit's pattern to hold stable.
- Decodes each stable pattern back to BCD, holds one BCD nibble per digit, and pulses when a full frame of digits has been captured.
- Used by self-check logic and display-readback paths.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE, 3, consecutive identical samples of {dig_sel, seven} required before commit (2..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- seven  input  7 [7:1]  segment lines, bit order g,f,e,d,c,b,a (seven[1]=a), 1 = lit; synchronous to clk.
- dig_sel  input  NDIG  active-high digit select, expected one-hot; synchronous to clk.
- bcd_out  output  4*NDIG  decoded BCD, digit i at [4i+3:4i].
- err_out  output  NDIG  bit i = last committed pattern for digit i was illegal.
- frame_valid  output  1  one-cycle pulse, every digit committed since last pulse.
- scan_err  output  1  one-cycle pulse, stable dig_sel not one-hot and non-zero.

Behaviour:
- Reset, synchronous and active-high:
  - bcd_out = all 4'hF; err_out = 0; frame_valid = 0; scan_err = 0.
  - Commit mask = 0; prev sample = 0; stability count cnt = 0.
- Reset mid-operation discards the partial frame and stability count. No output pulse is produced on the reset cycle or the cycle after it.
- Each edge: sample s = {dig_sel, seven}.
  - If cnt != 0 and s == prev: cnt <= min(cnt+1, STABLE).
  - Otherwise: cnt <= 1.
  - prev <= s.
- Commit event occurs when s == prev, cnt == STABLE-1 (pre-edge), and dig_sel is one-hot.
  - Exactly one commit per stable run; a held pattern never re-commits.
  - It needs a change and a new stable run.
  - On the commit edge, slot i (the set dig_sel bit) takes the decoded value.
  - bcd_out and err_out update on that edge, i.e. the value is visible STABLE cycles after the pattern first appears.
- Decode table (seven[7:1] -> bcd, err):
  - 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9, each with err=0.
  - 0000000 (blank) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- Stable dig_sel == 0:
  - No commit, no error; treated as blanking interval.
- Stable dig_sel multi-hot (same qualification point as a commit):
  - scan_err pulses for one cycle after that edge.
  - No slot is updated.
- Commit mask:
  - The mask bit for slot i is set on commit.
  - Re-commit of an already-set slot overwrites bcd/err and leaves the mask unchanged.
- Frame completion:
  - When a commit makes the mask all-ones, frame_valid is 1 for exactly the next cycle and the mask clears on that same edge.
  - bcd_out for the frame is already valid when frame_valid is high.
- No backpressure. frame_valid is informational; bcd_out holds until overwritten.

State machine (per stability tracker):
- IDLE (cnt=0): after reset, first sample goes to COUNT.
- COUNT (0 < cnt < STABLE): match increments; mismatch restarts at 1; reaching STABLE commits or flags.
- HELD (cnt=STABLE): match stays, mismatch goes to COUNT with cnt=1.

Decomposition:
- Shared package seven_seg_pkg:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK, shared with the encoder.
  - BCD_BLANK = 4'hF and BCD_BAD = 4'hE.
  - Function or localparam for one-hot check.
- Sub-module seven_bcd: purely combinational inverse lookup, seven[7:1] -> {bcd[3:0], err}.
  - Instantiated once, on the sampled pattern.
- Top holds the stability tracker, slot registers, mask and pulses.

Test Plan:
- Reset check: rst high 2 cycles -> bcd_out = 16'hFFFF, err_out = 0, no pulses.
- Full frame (NDIG=4, STABLE=3): hold each pattern 4 cycles: dig_sel=0001 with 1001111, dig_sel=0010 with 1101101, dig_sel=0100 with 0000110, dig_sel=1000 with 1111111 -> bcd_out = 16'h8153.
  - Each slot updates 3 cycles after its pattern appears.
  - frame_valid high for exactly 1 cycle after the digit-3 commit.
- Glitch rejection: dig_sel=0001, seven=1101101 for 2 cycles then 0111111 for 3 cycles -> slot0 = 0 only; 5 never committed.
- Illegal and blank patterns:
  - Stable 1010101 on digit 1 -> slot1 = 4'hE, err_out[1] = 1.
  - Then stable 0000000 on digit 1 -> slot1 = 4'hF, err_out[1] = 0.
- Multi-hot select: stable dig_sel=0011 for 3 cycles -> scan_err 1-cycle pulse, bcd_out unchanged, no frame_valid.
- Reset mid-frame: commit digits 0 and 1, assert rst 1 cycle, then commit digits 2 and 3 -> no frame_valid until all four digits are committed again after reset.
